// File: rtl/t_clk_divn_pkg.sv
// t_clk_divn_pkg: shared state encoding and divide-ratio helpers for the clock-enable divider.
package t_clk_divn_pkg;
  typedef enum logic [1:0] {RUN, CHECK, DONE} state_t;
  function automatic int div_of(input int div_base, input int ch);
    return (ch + 1) * div_base;
  endfunction
  function automatic int exp_count(input int check_cycles, input int div_base, input int ch);
    return check_cycles / div_of(div_base, ch);
  endfunction
endpackage

// File: rtl/t_clk_divn_chan.sv
// t_clk_divn_chan: one divider channel with prescaler, level toggle and saturating tick counter.
module t_clk_divn_chan #(
  parameter int N     = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clr,
  input  logic             en,
  output logic             tick,
  output logic             level,
  output logic [WIDTH-1:0] count
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] pre_q, pre_d;
  logic tick_q, tick_d, level_q, level_d, wrap;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    wrap    = en && pre_q == PW'(N - 1);
    pre_d   = (clr || wrap) ? '0 : en ? pre_q + 1'b1 : pre_q;
    tick_d  = wrap && !clr;
    level_d = clr ? 1'b0 : level_q ^ wrap;
    cnt_d   = clr ? '0 : (wrap && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end
  assign tick  = tick_q;
  assign level = level_q;
  assign count = cnt_q;
endmodule

// File: rtl/t_clk_divn.sv
// t_clk_divn: divided tick enables with a self-checking tick counter; T_CLK_DIVN_TRACE_EN adds $write tracing.
module t_clk_divn
  import t_clk_divn_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int DIV_BASE     = 2,
  parameter int WIDTH        = 8,
  parameter int CHECK_CYCLES = 48,
  localparam int FW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic                start,
  input  logic [CHANNELS-1:0] hold,
  output logic [CHANNELS-1:0] ch_tick,
  output logic [CHANNELS-1:0] ch_level,
  output logic                busy,
  output logic                passed,
  output logic                failed,
  output logic [FW-1:0]       fail_ch
);
  localparam int CW = $clog2(CHECK_CYCLES + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [FW-1:0] idx_q, idx_d, fail_ch_q, fail_ch_d;
  logic err_q, err_d, passed_q, passed_d, failed_q, failed_d, busy_q, busy_d;
  logic run, clr, mis, last;
  logic [WIDTH-1:0] cnt [CHANNELS];
  logic [WIDTH-1:0] exp_cnt [CHANNELS];
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    t_clk_divn_chan #(.N(div_of(DIV_BASE, g)), .WIDTH(WIDTH)) u_chan (
      .clk,
      .reset_l,
      .clr,
      .en   (run && !hold[g]),
      .tick (ch_tick[g]),
      .level(ch_level[g]),
      .count(cnt[g])
    );
    assign exp_cnt[g] = WIDTH'(exp_count(CHECK_CYCLES, DIV_BASE, g));
  end
  always_comb begin
    run       = state_q == RUN;
    clr       = state_q == DONE && start;
    last      = idx_q == FW'(CHANNELS - 1);
    mis       = state_q == CHECK && cnt[idx_q] != exp_cnt[idx_q];
    cyc_d     = clr ? '0 : run ? cyc_q + 1'b1 : cyc_q;
    state_d   = clr ? RUN
              : (run && cyc_q == CW'(CHECK_CYCLES - 1)) ? CHECK
              : (state_q == CHECK && last) ? DONE : state_q;
    idx_d     = clr ? '0 : (state_q == CHECK && !last) ? idx_q + 1'b1 : idx_q;
    err_d     = clr ? 1'b0 : err_q | mis;
    fail_ch_d = clr ? '0 : (mis && !err_q) ? idx_q : fail_ch_q;
    passed_d  = clr ? 1'b0 : (state_q == CHECK && last) ? !(err_q || mis) : passed_q;
    failed_d  = clr ? 1'b0 : (state_q == CHECK && last) ? (err_q || mis) : failed_q;
    busy_d    = state_d != DONE;
  end
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q   <= RUN;
      cyc_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      fail_ch_q <= '0;
      passed_q  <= 1'b0;
      failed_q  <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      fail_ch_q <= fail_ch_d;
      passed_q  <= passed_d;
      failed_q  <= failed_d;
      busy_q    <= busy_d;
    end
  end
`ifdef T_CLK_DIVN_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset_l) begin
      if (clr) $write("[%0t] t_clk_divn: Running\n", $time);
      if (mis) $write("[%0t] t_clk_divn: Failed ch=%0d exp=%0d got=%0d\n", $time, idx_q, exp_cnt[idx_q], cnt[idx_q]);
      if (state_q == CHECK && last && !(err_q || mis)) $write("[%0t] t_clk_divn: Passed\n", $time);
      if (state_q == CHECK && last && (err_q || mis))
        $write("[%0t] t_clk_divn: Failed ch=%0d exp=%0d got=%0d\n", $time, fail_ch_d, exp_cnt[fail_ch_d], cnt[fail_ch_d]);
    end
  end
`endif
  assign busy    = busy_q;
  assign passed  = passed_q;
  assign failed  = failed_q;
  assign fail_ch = fail_ch_q;
endmodule

// File: tb/tb_t_clk_divn.sv
// tb_t_clk_divn: directed checks of the default divider and a CHANNELS=1 / DIV_BASE=1 / 255-cycle instance.
module tb_t_clk_divn;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_l, rst1_l, start;
  logic [3:0] hold, ch_tick, ch_level;
  logic busy, passed, failed;
  logic [1:0] fail_ch;
  logic t1, l1, b1, p1, f1, fc1;
  int errors = 0, checks = 0, bad = 0;

  t_clk_divn dut (
    .clk(clk), .reset_l(reset_l), .start(start), .hold(hold), .ch_tick(ch_tick), .ch_level(ch_level),
    .busy(busy), .passed(passed), .failed(failed), .fail_ch(fail_ch)
  );
  t_clk_divn #(.CHANNELS(1), .DIV_BASE(1), .WIDTH(8), .CHECK_CYCLES(255)) dut1 (
    .clk(clk), .reset_l(rst1_l), .start(1'b0), .hold(1'b0), .ch_tick(t1), .ch_level(l1),
    .busy(b1), .passed(p1), .failed(f1), .fail_ch(fc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    step(1);
    reset_l = 1'b1;
  endtask

  function automatic logic [7:0] exp_vec(input int k);
    logic [7:0] v;
    int n, m;
    v = '0;
    m = k < 48 ? k : 48;
    for (int i = 0; i < 4; i++) begin
      n = (i + 1) * 2;
      v[i]     = k <= 48 && k % n == 0;
      v[4 + i] = (m / n) % 2 == 1;
    end
    return v;
  endfunction

  initial begin
    reset_l = 1'b0; rst1_l = 1'b0; start = 1'b0; hold = '0;
    step(1);
    check("rst_tick", 32'(ch_tick), 0);
    check("rst_level", 32'(ch_level), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_passed", 32'(passed), 0);
    check("rst_failed", 32'(failed), 0);
    check("rst_fail_ch", 32'(fail_ch), 0);
    reset_l = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      step(1);
      check($sformatf("vec_k%0d", k), 32'({ch_level, ch_tick}), 32'(exp_vec(k)));
      if (k == 51) check("busy_k51", 32'(busy), 1);
    end
    check("t1_passed", 32'(passed), 1);
    check("t1_failed", 32'(failed), 0);
    check("t1_busy", 32'(busy), 0);
    do_reset();
    step(2); hold = 4'b0010; step(5); hold = '0; step(45);
    check("t2_failed", 32'(failed), 1);
    check("t2_passed", 32'(passed), 0);
    check("t2_fail_ch", 32'(fail_ch), 1);
    do_reset();
    step(2); hold = 4'b1010; step(10); hold = '0; step(40);
    check("t3_failed", 32'(failed), 1);
    check("t3_fail_ch", 32'(fail_ch), 1);
    check("t3_level", 32'(ch_level), 32'h2);
    start = 1'b1; step(1); start = 1'b0;
    check("rs_busy", 32'(busy), 1);
    check("rs_failed", 32'(failed), 0);
    check("rs_fail_ch", 32'(fail_ch), 0);
    check("rs_level", 32'(ch_level), 0);
    step(9); start = 1'b1; step(1); start = 1'b0; step(41);
    check("rs_busy_k51", 32'(busy), 1);
    step(1);
    check("rs_passed", 32'(passed), 1);
    check("rs_busy_k52", 32'(busy), 0);
    do_reset();
    step(29);
    reset_l = 1'b0; step(1);
    check("mr_busy", 32'(busy), 1);
    check("mr_level", 32'(ch_level), 0);
    check("mr_tick", 32'(ch_tick), 0);
    reset_l = 1'b1;
    step(51);
    check("mr_busy_k51", 32'(busy), 1);
    check("mr_passed_k51", 32'(passed), 0);
    step(1);
    check("mr_passed", 32'(passed), 1);
    check("mr_failed", 32'(failed), 0);
    step(1);
    rst1_l = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      step(1);
      if (t1 !== 1'b1) bad++;
    end
    check("d1_tick_all", 32'(bad), 0);
    check("d1_busy_k255", 32'(b1), 1);
    step(1);
    check("d1_tick_k256", 32'(t1), 0);
    check("d1_passed", 32'(p1), 1);
    check("d1_failed", 32'(f1), 0);
    check("d1_busy", 32'(b1), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/t_clk_divn.md
# t_clk_divn

Parametrised clock-enable generator and self-checking tick counter for the clocking test suite. From a single `clk`, it derives `CHANNELS` divided tick strobes and square-wave levels, where channel i divides by N_i = (i+1)*DIV_BASE. It counts each channel's ticks over a fixed window, then sequentially checks every count against its expected value and latches `passed` or `failed`. All derived timing is expressed as enables, not generated clocks, so it sits alongside the existing clock tests without GENCLK waivers.

## Interface
- `CHANNELS`, 4: number of divider channels, 1..16.
- `DIV_BASE`, 2: base divide ratio; channel i divides by N_i = (i+1)*DIV_BASE; must be ≥1.
- `WIDTH`, 8: tick-counter width; CHECK_CYCLES/DIV_BASE must be < 2^WIDTH.
- `CHECK_CYCLES`, 48: length of the counting window in `clk` cycles; must be ≥1.
- `clk` input 1: sole clock, rising edge.
- `reset_l` input 1: reset. One clock; reset is synchronous and active-low.
- `start` input 1: restart pulse; honoured only in DONE.
- `hold` input CHANNELS: per-channel stall; while bit i is high, prescaler i does not advance.
- `ch_tick` output CHANNELS: one-cycle strobe per channel.
- `ch_level` output CHANNELS: toggles on each tick; period is 2*N_i.
- `busy` output 1: high in RUN or CHECK.
- `passed` output 1: latched pass.
- `failed` output 1: latched fail.
- `fail_ch` output max(1,$clog2(CHANNELS)): lowest failing channel index.

## Operation
- FSM states: RUN, CHECK, DONE.
  - Reset puts the FSM in RUN with the cycle counter `cyc`=0 and all prescalers, tick counters and the check index at 0.
  - Reset values: `ch_tick`=0, `ch_level`=0, `passed`=0, `failed`=0, `fail_ch`=0, `busy`=1.
- RUN:
  - Each edge increments `cyc`.
  - Prescaler i advances unless `hold[i]` is high. When it wraps (reaches N_i-1 and advances), that edge:
    - sets `ch_tick[i]` for one cycle,
    - toggles `ch_level[i]`,
    - increments tick count i. The count saturates at 2^WIDTH-1.
  - The edge where `cyc` reaches CHECK_CYCLES moves the FSM to CHECK. Ticks on that edge are counted.
- CHECK:
  - Prescalers and counts are frozen; no ticks occur.
  - One channel is compared per cycle, index 0 first, against E_i = floor(CHECK_CYCLES/N_i).
  - On the first mismatch, record `fail_ch` and set a sticky error flag. Later mismatches do not overwrite `fail_ch`.
  - After the last channel, the FSM moves to DONE and sets `passed`=!err and `failed`=err on that edge.
- DONE:
  - Outputs hold; `busy`=0.
  - `start`=1 returns the FSM to RUN on the next edge and clears `cyc`, prescalers, counts, `ch_level`, `passed`, `failed`, `fail_ch` and the error flag.
- `start` in RUN or CHECK is ignored. `hold` in CHECK or DONE has no effect.
- `reset_l` low at any edge, including mid-RUN or mid-CHECK, overrides everything else and restores the reset values.

## Timing
- Edges are numbered k=1,2,… from the first edge that samples `reset_l` high.
- Without `hold`, `ch_tick[i]` is high in the cycle after every edge where k mod N_i = 0 and k ≤ CHECK_CYCLES.
- Check phase: CHECK occupies edges CHECK_CYCLES+1 through CHECK_CYCLES+CHANNELS.
- Result: `passed`/`failed` become visible after edge CHECK_CYCLES+CHANNELS.
- After `start` is sampled in DONE, the same numbering restarts from the next edge.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- Macro: `T_CLK_DIVN_TRACE_EN`.
- Defined: the block prints `[%0t] t_clk_divn: Running` on entry to RUN, `[%0t] t_clk_divn: Passed` or `[%0t] t_clk_divn: Failed ch=%0d exp=%0d got=%0d` on entry to DONE, and the same mismatch detail for every failing channel during CHECK.
- Undefined: no `$write` calls are compiled in. Register behaviour is identical either way.

## Structure
- Package `t_clk_divn_pkg` holds:
  - the state enum (RUN, CHECK, DONE),
  - function `exp_count(check_cycles, div_base, ch)` returning floor(check_cycles/((ch+1)*div_base)),
  - function `div_of(div_base, ch)`.
- Sub-module `t_clk_divn_chan`: one prescaler, level toggle and saturating counter. It takes `clk`, `reset_l`, a clear, an enable (RUN & !hold) and parameter N, and produces tick, level and count. It is instantiated CHANNELS times in a generate loop.
- The top level owns `cyc`, the FSM, the check index, the error flag and the result registers.

## Test plan
- Defaults (N=2,4,6,8; E=24,12,8,6), no `hold`:
  - `passed`=1 and `failed`=0 appear after edge 52;
  - `busy` falls at the same edge;
  - `ch_tick[3]` pulses after edges 8,16,…,48.
- `hold[1]` high for 5 cycles during RUN:
  - channel 1 counts 10 ≠ 12;
  - `failed`=1 and `fail_ch`=1 after edge 52.
- `hold[1]` and `hold[3]` both high for 10 cycles:
  - `fail_ch`=1, the lowest failing index;
  - `failed`=1.
- `reset_l` low for one edge at k=30, then released:
  - all counters restart;
  - the result appears 52 edges after the release, with `passed`=1.
- In DONE, pulse `start`; also pulse `start` at k=10 of the new run:
  - the mid-run pulse is ignored;
  - the new run passes after edge 52 from the restart.
- CHANNELS=1, DIV_BASE=1, CHECK_CYCLES=255, WIDTH=8:
  - `ch_tick[0]` is high every cycle;
  - the count is 255 and is not wrapped;
  - `passed`=1 after edge 256.
